// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and a constant-function clog2 used to size the step counter.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Never returns less than 1 so a one-step divider still gets a real counter.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/div_step_cell.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
module div_step_cell #(
    parameter int DIVLEN_2 = 4
) (
    input  logic [DIVLEN_2-1:0] pr_i,
    input  logic                dvd_bit_i,
    input  logic [DIVLEN_2-1:0] divisor_i,
    output logic [DIVLEN_2-1:0] pr_o,
    output logic                qbit_o
);

    logic [DIVLEN_2:0] pr_shift;

    // The restored remainder is always below the divisor, so the narrow
    // subtraction cannot lose its top bit.
    always_comb begin
        pr_shift = {pr_i, dvd_bit_i};
        qbit_o   = (pr_shift >= {1'b0, divisor_i});
        pr_o     = qbit_o ? (pr_shift[DIVLEN_2-1:0] - divisor_i) : pr_shift[DIVLEN_2-1:0];
    end

endmodule

// File: rtl/div_seq.sv
// Iterative restoring divider, one quotient bit per cycle, MSB first.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division).
module div_seq
    import div_pkg::*;
#(
    parameter int DIVLEN_1 = 8,
    parameter int DIVLEN_2 = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DIVLEN_1-1:0] dividend,
    input  logic [DIVLEN_2-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [DIVLEN_1-1:0] quotient,
    output logic [DIVLEN_2-1:0] remainder,
    output logic                div_zero,
    output div_state_e          dbg_state_o
);

    localparam int CW = clog2(DIVLEN_1);

    div_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DIVLEN_1-1:0] dq_q, dq_d;
    logic [DIVLEN_2-1:0] pr_q, pr_d;
    logic [DIVLEN_2-1:0] dvs_q, dvs_d;
    logic                dz_q, dz_d;
    logic                done_q, done_d;
    logic [DIVLEN_1-1:0] quotient_q, quotient_d;
    logic [DIVLEN_2-1:0] remainder_q, remainder_d;
    logic                div_zero_q, div_zero_d;
    logic [DIVLEN_1-1:0] q_res;
    logic [DIVLEN_2-1:0] r_res;
    logic [DIVLEN_2-1:0] pr_step;
    logic                qbit;
`ifdef DIV_SIGNED_EN
    logic                neg_q_q, neg_q_d;
    logic                neg_r_q, neg_r_d;
`endif

    // dq_q holds the dividend and shifts left each step; quotient bits fill in from the LSB.
    div_step_cell #(.DIVLEN_2(DIVLEN_2)) u_step (
        .pr_i      (pr_q),
        .dvd_bit_i (dq_q[DIVLEN_1-1]),
        .divisor_i (dvs_q),
        .pr_o      (pr_step),
        .qbit_o    (qbit)
    );

`ifdef DIV_SIGNED_EN
    always_comb begin
        q_res = neg_q_q ? (~dq_q + DIVLEN_1'(1)) : dq_q;
        r_res = neg_r_q ? (~pr_q + DIVLEN_2'(1)) : pr_q;
    end
`else
    always_comb begin
        q_res = dq_q;
        r_res = pr_q;
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dq_d        = dq_q;
        pr_d        = pr_q;
        dvs_d       = dvs_q;
        dz_d        = dz_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
`ifdef DIV_SIGNED_EN
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    pr_d  = '0;
                    cnt_d = '0;
                    dz_d  = (divisor == '0);
`ifdef DIV_SIGNED_EN
                    // Zero divisor keeps the raw dividend so its low bits form the remainder.
                    dvs_d   = divisor[DIVLEN_2-1] ? (~divisor + DIVLEN_2'(1)) : divisor;
                    dq_d    = (dividend[DIVLEN_1-1] && (divisor != '0)) ?
                              (~dividend + DIVLEN_1'(1)) : dividend;
                    neg_q_d = dividend[DIVLEN_1-1] ^ divisor[DIVLEN_2-1];
                    neg_r_d = dividend[DIVLEN_1-1];
`else
                    dvs_d   = divisor;
                    dq_d    = dividend;
`endif
                    state_d = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                dq_d  = {dq_q[DIVLEN_1-2:0], qbit};
                pr_d  = pr_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DIVLEN_1 - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d    = IDLE;
                done_d     = 1'b1;
                div_zero_d = dz_q;
                if (dz_q) begin
                    quotient_d  = '1;
                    remainder_d = dq_q[DIVLEN_2-1:0];
                end else begin
                    quotient_d  = q_res;
                    remainder_d = r_res;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dq_q        <= '0;
            pr_q        <= '0;
            dvs_q       <= '0;
            dz_q        <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dq_q        <= dq_d;
            pr_q        <= pr_d;
            dvs_q       <= dvs_d;
            dz_q        <= dz_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
`ifdef DIV_SIGNED_EN
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
`endif
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_zero    = div_zero_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq (DIVLEN_1=8, DIVLEN_2=4); expected
// values are hand-computed and switch with DIV_SIGNED_EN.
module tb_div_seq;
    import div_pkg::*;

    localparam int LAT_CALC = 9;
    localparam int LAT_ZERO = 1;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;
    div_state_e dbg_state;

    int n_checks;
    int n_fail;

    div_seq #(.DIVLEN_1(8), .DIVLEN_2(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_zero    (div_zero),
        .dbg_state_o (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait (bounded) for its done pulse.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] exp_q, input logic [3:0] exp_r,
                          input logic exp_dz, input int exp_lat);
        int cyc;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check({tag, " busy"}, 32'(busy), 32'd1);
        dividend = 8'($urandom_range(0, 255));
        divisor  = 4'($urandom_range(0, 15));
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc = cyc + 1;
        end
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " q"}, 32'(quotient), 32'(exp_q));
        check({tag, " r"}, 32'(remainder), 32'(exp_r));
        check({tag, " dz"}, 32'(div_zero), 32'(exp_dz));
    endtask

`ifdef DIV_SIGNED_EN
    localparam logic [7:0] Q_200_7   = 8'hF8;
    localparam logic [3:0] R_200_7   = 4'h0;
    localparam logic [7:0] Q_15_15   = 8'hF1;
    localparam logic [3:0] R_15_15   = 4'h0;
    logic [7:0] v_a [5] = '{8'd100, 8'h9C, 8'h80, 8'h9C, 8'hF9};
    logic [3:0] v_b [5] = '{4'h9,   4'h7,  4'hF,  4'h9,  4'h2};
    logic [7:0] v_q [5] = '{8'hF2,  8'hF2, 8'h80, 8'h0E, 8'hFD};
    logic [3:0] v_r [5] = '{4'h2,   4'hE,  4'h0,  4'hE,  4'hF};
`else
    localparam logic [7:0] Q_200_7   = 8'd28;
    localparam logic [3:0] R_200_7   = 4'd4;
    localparam logic [7:0] Q_15_15   = 8'd1;
    localparam logic [3:0] R_15_15   = 4'd0;
    logic [7:0] v_a [5] = '{8'd255, 8'd7, 8'd255, 8'd254, 8'd128};
    logic [3:0] v_b [5] = '{4'd1,   4'd9, 4'd15,  4'd13,  4'd8};
    logic [7:0] v_q [5] = '{8'd255, 8'd0, 8'd17,  8'd19,  8'd16};
    logic [3:0] v_r [5] = '{4'd0,   4'd7, 4'd0,   4'd7,   4'd0};
`endif

    initial begin
        int cyc;
        int n_done;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state
        #12;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst q", 32'(quotient), 32'd0);
        check("rst r", 32'(remainder), 32'd0);
        check("rst dz", 32'(div_zero), 32'd0);
        check("rst state", 32'(dbg_state), 32'(IDLE));
        tick();
        rst_n = 1'b1;
        tick();

        // Basic divide, then done must drop after one cycle and results hold
        run_op("200/7", 8'd200, 4'd7, Q_200_7, R_200_7, 1'b0, LAT_CALC);
        tick();
        check("200/7 done pulse", 32'(done), 32'd0);
        check("200/7 q hold", 32'(quotient), 32'(Q_200_7));
        check("200/7 idle", 32'(busy), 32'd0);

        // Back-to-back: second start issued in the done cycle (DUT already IDLE)
        run_op("15/15", 8'd15, 4'd15, Q_15_15, R_15_15, 1'b0, LAT_CALC);
        run_op("0/3", 8'd0, 4'd3, 8'd0, 4'd0, 1'b0, LAT_CALC);
        tick();

        // Divide by zero
        run_op("100/0", 8'd100, 4'd0, 8'hFF, 4'd4, 1'b1, LAT_ZERO);
        tick();
        check("100/0 done pulse", 32'(done), 32'd0);

        // start held high through CALC/DONE with changing operands
        dividend = 8'd50;
        divisor  = 4'd6;
        start    = 1'b1;
        tick();
        dividend = 8'd255;
        divisor  = 4'd1;
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc = cyc + 1;
        end
        start = 1'b0;
        check("hold latency", 32'(cyc), 32'(LAT_CALC));
        check("hold q", 32'(quotient), 32'd8);
        check("hold r", 32'(remainder), 32'd2);
        n_done = 0;
        repeat (12) begin
            tick();
            if (done) n_done = n_done + 1;
        end
        check("hold extra done", 32'(n_done), 32'd0);
        check("hold busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of CALC
        dividend = 8'd77;
        divisor  = 4'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort state", 32'(dbg_state), 32'(IDLE));
        check("abort q", 32'(quotient), 32'd0);
        n_done = 0;
        repeat (3) begin
            tick();
            if (done) n_done = n_done + 1;
        end
        rst_n = 1'b1;
        repeat (12) begin
            tick();
            if (done) n_done = n_done + 1;
        end
        check("abort done", 32'(n_done), 32'd0);
        run_op("9/2", 8'd9, 4'd2, 8'd4, 4'd1, 1'b0, LAT_CALC);
        tick();

        // Further directed vectors
        for (int i = 0; i < 5; i++) begin
            run_op($sformatf("vec%0d", i), v_a[i], v_b[i], v_q[i], v_r[i], 1'b0, LAT_CALC);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
